instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs an opcode, register fields and a 32-bit signed immediate into a 32-bit RV32I instruction word for I-, S- or B-type formats.
- Feeds the instruction-memory loader and test-program builder.
- Valid/ready input and output with a one-deep registered output stage.
- Tracks the sequential instruction address.
- Rejects immediates that the selected format cannot represent.

Parameters:
- ADDR_W, 32, width of instr_addr.
- BASE_ADDR, 32'h0000_0000, address assigned to the first emitted word after reset.
- ERR_CNT_W, 8, width of err_count.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- imm_src  input  2  format select: 00 I, 01 S, 10 B, 11 illegal (same code as ImmSrc).
- imm_in  input  32  signed immediate, byte offset for B.
- opcode  input  7  instr[6:0].
- rd  input  5  destination register (I only).
- rs1  input  5  source register 1.
- rs2  input  5  source register 2 (S/B only).
- funct3  input  3  instr[14:12].
- out_valid  output  1  instr_out/instr_addr valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- instr_out  output  32  encoded word.
- instr_addr  output  ADDR_W  address of instr_out.
- err_range  output  1  sticky: some request was rejected.
- err_count  output  ERR_CNT_W  number of rejected requests, saturating.

Behaviour:
- Reset, on the clk edge with rst_n=0:
  - out_valid=0, instr_out=0, instr_addr=BASE_ADDR, err_range=0, err_count=0.
  - Any pending word is discarded and not emitted.
- in_ready = !out_valid || out_ready. It is combinational and asserts during reset with in_valid ignored.
- Latency: an accepted legal request appears on instr_out with out_valid=1 on the next cycle.
- Registered outputs hold stable while out_valid && !out_ready.
- Output handshake cycle with no new legal accept: out_valid drops to 0.
- Output handshake and new legal accept in the same cycle: the new word replaces the old one. There is no bubble, giving full throughput.
- Address rule:
  - instr_addr increments by 4 after each completed output handshake, wrapping modulo 2^ADDR_W.
  - The first emitted word carries BASE_ADDR.
  - The address of a word loaded on the same cycle as a handshake is the incremented value.
- Encoding:
  - I: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]=opcode.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0], [6:0]=opcode.
  - B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11], [6:0]=opcode.
- Range check (legal request):
  - I/S legal iff imm_in is in [-2048, 2047] (bits [31:11] all equal).
  - B legal iff imm_in is in [-4096, 4094] and imm_in[0]=0.
  - imm_src=11 is always illegal.
- Illegal request:
  - Accepted with the normal handshake, producing no output word.
  - The address does not advance.
  - err_range is set to 1 and stays set until reset.
  - err_count increments and saturates at all-ones.
  - If the accept coincides with an output handshake, out_valid drops to 0 for that cycle.
- Fields not used by the selected format are ignored.

Optional Feature:
- Macro: INSTR_ENCODER_ROUNDTRIP_CHECK_EN.
- When defined:
  - Adds output rt_mismatch (1 bit, reset 0).
  - Each loaded word is decoded with the immediate-generator rules (sign-extend bit 31).
  - rt_mismatch is set sticky if the decoded immediate differs from the accepted imm_in. It must never fire for legal requests.
- When undefined: the port and logic are absent, and behaviour is otherwise identical.

Test Plan:
- I-type addi x1,x0,5 (imm_src=00, imm=5, opcode=7'h13, rd=1, rs1=0, funct3=0), out_ready=1 -> next cycle out_valid=1, instr_out=32'h00500093, instr_addr=BASE_ADDR.
- S-type sw x2,8(x1) (imm_src=01, imm=8, rs1=1, rs2=2, funct3=3'b010, opcode=7'h23) directly after the I-type -> instr_out=32'h0020A423, instr_addr=BASE_ADDR+4, no bubble.
- B-type beq x1,x2,-4 (imm_src=10, imm=-4, rs1=1, rs2=2, funct3=0, opcode=7'h63) -> instr_out=32'hFE208EE3.
- Illegal cases:
  - I with imm=2048 -> no output word, err_range=1, err_count=1.
  - B with imm=3 -> err_count=2.
  - imm_src=11 -> err_count=3.
  - A following legal word keeps the unadvanced address.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, instr_out/instr_addr stable. Raise out_ready -> handshake, address +4.
- Reset mid-operation: rst_n=0 for one cycle while out_valid=1 and err_count=2 -> out_valid=0, err_range=0, err_count=0. The next word emits at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: the request channel (valid/ready plus
// instruction fields) and the registered output channel (valid/ready plus word and address).
interface instr_encoder_if #(
  parameter int ADDR_W = 32
) ();
  // Request channel
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        imm_src;
  logic [31:0]       imm_in;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;

  // Output channel
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] instr_addr;

  // Producer of requests and consumer of encoded words
  modport master (
    output in_valid, imm_src, imm_in, opcode, rd, rs1, rs2, funct3, out_ready,
    input  in_ready, out_valid, instr_out, instr_addr
  );

  // The encoder itself
  modport slave (
    input  in_valid, imm_src, imm_in, opcode, rd, rs1, rs2, funct3, out_ready,
    output in_ready, out_valid, instr_out, instr_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I I/S/B instruction encoder with range check, address tracking and a one-deep output
// register. Optional macro INSTR_ENCODER_ROUNDTRIP_CHECK_EN adds a sticky rt_mismatch decoder check.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_encoder_if.slave       bus,
  output logic                 err_range,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef INSTR_ENCODER_ROUNDTRIP_CHECK_EN
  ,
  output logic                 rt_mismatch
`endif
);

  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_S   = 2'b01,
    FMT_B   = 2'b10,
    FMT_BAD = 2'b11
  } imm_fmt_e;

  logic                 r_out_valid;
  logic [31:0]          r_instr;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_err_range;
  logic [ERR_CNT_W-1:0] r_err_count;

  imm_fmt_e             w_fmt;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_out_hs;
  logic                 w_fits12;
  logic                 w_fits13;
  logic                 w_legal;
  logic [31:0]          w_word;

  assign w_fmt = imm_fmt_e'(bus.imm_src);

  // Ready is forced high while in reset; any request presented then is simply not taken.
  assign w_in_ready = !rst_n || !r_out_valid || bus.out_ready;
  assign w_accept   = rst_n && bus.in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && bus.out_ready;

  // A value fits a signed N-bit field when every bit above the field's sign bit matches it.
  assign w_fits12 = (&bus.imm_in[31:11]) || !(|bus.imm_in[31:11]);
  assign w_fits13 = (&bus.imm_in[31:12]) || !(|bus.imm_in[31:12]);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_word  = '0;
    w_legal = 1'b0;
    unique case (w_fmt)
      FMT_I: begin
        w_word  = {bus.imm_in[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        w_legal = w_fits12;
      end
      FMT_S: begin
        w_word  = {bus.imm_in[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm_in[4:0], bus.opcode};
        w_legal = w_fits12;
      end
      FMT_B: begin
        w_word  = {bus.imm_in[12], bus.imm_in[10:5], bus.rs2, bus.rs1, bus.funct3,
                   bus.imm_in[4:1], bus.imm_in[11], bus.opcode};
        w_legal = w_fits13 && !bus.imm_in[0];
      end
      default: begin
        w_word  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_addr      <= BASE_ADDR;
      r_err_range <= 1'b0;
      r_err_count <= '0;
    end else begin
      // The address names the word currently held, so it moves only when that word leaves.
      if (w_out_hs) begin
        r_addr <= r_addr + ADDR_W'(4);
      end

      if (w_accept && w_legal) begin
        r_out_valid <= 1'b1;
        r_instr     <= w_word;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept && !w_legal) begin
        r_err_range <= 1'b1;
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
      end
    end
  end

`ifdef INSTR_ENCODER_ROUNDTRIP_CHECK_EN
  logic [31:0] w_rt_imm;
  logic        r_rt_mismatch;

  // Decode the freshly built word exactly as the immediate generator would.
  always_comb begin
    w_rt_imm = '0;
    unique case (w_fmt)
      FMT_I:   w_rt_imm = {{20{w_word[31]}}, w_word[31:20]};
      FMT_S:   w_rt_imm = {{20{w_word[31]}}, w_word[31:25], w_word[11:7]};
      FMT_B:   w_rt_imm = {{19{w_word[31]}}, w_word[31], w_word[7], w_word[30:25],
                           w_word[11:8], 1'b0};
      default: w_rt_imm = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rt_mismatch <= 1'b0;
    end else if (w_accept && w_legal && (w_rt_imm != bus.imm_in)) begin
      r_rt_mismatch <= 1'b1;
    end
  end

  assign rt_mismatch = r_rt_mismatch;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.instr_out  = r_instr;
  assign bus.instr_addr = r_addr;
  assign err_range      = r_err_range;
  assign err_count      = r_err_count;

endmodule
